// File: rtl/md_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the E stage; owns HI and LO.
// Optional madd/maddu/msub/msubu decode is enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             start,
  output logic             busy,
  output logic             is_md,
  output logic [WIDTH-1:0] md_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * WIDTH;

  typedef enum logic [3:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
    OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
  } op_e;

  op_e             op;
  logic            op_start;
  logic            op_idle;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] hi_nxt_q, hi_nxt_d, lo_nxt_q, lo_nxt_d;
  logic [W2-1:0]   prod_s, prod_u, acc;
  logic [WIDTH-1:0] q_s, r_s, q_u, r_u;
  logic            div_ovf;
  logic            unused_instr;

  assign unused_instr = ^instr[25:6];

  always_comb begin
    op = OP_NONE;
    if (instr[31:26] == 6'b000000) begin
      case (instr[5:0])
        6'b011000: op = OP_MULT;
        6'b011001: op = OP_MULTU;
        6'b011010: op = OP_DIV;
        6'b011011: op = OP_DIVU;
        6'b010000: op = OP_MFHI;
        6'b010001: op = OP_MTHI;
        6'b010010: op = OP_MFLO;
        6'b010011: op = OP_MTLO;
        default:   op = OP_NONE;
      endcase
    end
`ifdef MD_MADD_EN
    else if (instr[31:26] == 6'b011100) begin
      case (instr[5:0])
        6'b000000: op = OP_MADD;
        6'b000001: op = OP_MADDU;
        6'b000100: op = OP_MSUB;
        6'b000101: op = OP_MSUBU;
        default:   op = OP_NONE;
      endcase
    end
`endif
  end

  assign op_start = (op == OP_MULT) || (op == OP_MULTU) ||
                    (op == OP_DIV)  || (op == OP_DIVU)  ||
                    (op == OP_MADD) || (op == OP_MADDU) ||
                    (op == OP_MSUB) || (op == OP_MSUBU);
  assign busy    = (cnt_q != '0);
  assign op_idle = valid && !busy;
  assign start   = op_idle && op_start;
  assign is_md   = valid && (op != OP_NONE);
  assign hi      = hi_q;
  assign lo      = lo_q;

  always_comb begin
    md_out = '0;
    if (valid && op == OP_MFHI) md_out = hi_q;
    if (valid && op == OP_MFLO) md_out = lo_q;
  end

  // Sign-extending to 2*WIDTH lets one unsigned multiplier yield the signed product.
  assign prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};
  assign prod_s = {{WIDTH{rs_val[WIDTH-1]}}, rs_val} *
                  {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
  assign acc    = {hi_q, lo_q};

  assign div_ovf = (rs_val == {1'b1, {(WIDTH-1){1'b0}}}) && (rt_val == '1);

  always_comb begin
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    if (rt_val != '0) begin
      q_u = rs_val / rt_val;
      r_u = rs_val % rt_val;
      if (div_ovf) begin
        q_s = rs_val;
        r_s = '0;
      end else begin
        q_s = WIDTH'($signed(rs_val) / $signed(rt_val));
        r_s = WIDTH'($signed(rs_val) % $signed(rt_val));
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_nxt_d = hi_nxt_q;
    lo_nxt_d = lo_nxt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        hi_d = hi_nxt_q;
        lo_d = lo_nxt_q;
      end
    end
    if (start) begin
      cnt_d = CW'(MULT_CYCLES);
      case (op)
        OP_MULT:  {hi_nxt_d, lo_nxt_d} = prod_s;
        OP_MULTU: {hi_nxt_d, lo_nxt_d} = prod_u;
        OP_MADD:  {hi_nxt_d, lo_nxt_d} = acc + prod_s;
        OP_MADDU: {hi_nxt_d, lo_nxt_d} = acc + prod_u;
        OP_MSUB:  {hi_nxt_d, lo_nxt_d} = acc - prod_s;
        OP_MSUBU: {hi_nxt_d, lo_nxt_d} = acc - prod_u;
        OP_DIV, OP_DIVU: begin
          cnt_d = CW'(DIV_CYCLES);
          // A zero divisor re-commits the current HI/LO so nothing changes.
          if (rt_val == '0) begin
            hi_nxt_d = hi_q;
            lo_nxt_d = lo_q;
          end else if (op == OP_DIV) begin
            hi_nxt_d = r_s;
            lo_nxt_d = q_s;
          end else begin
            hi_nxt_d = r_u;
            lo_nxt_d = q_u;
          end
        end
        default: ;
      endcase
    end
    if (op_idle && op == OP_MTHI) hi_d = rs_val;
    if (op_idle && op == OP_MTLO) lo_d = rs_val;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_nxt_q <= '0;
      lo_nxt_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_nxt_q <= hi_nxt_d;
      lo_nxt_q <= lo_nxt_d;
    end
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core, sitting in the E stage beside the ALU. It decodes the E-stage instruction for the HI/LO family (mult/multu/div/divu/mfhi/mflo/mthi/mtlo), runs the operation over a configurable number of cycles, and owns the HI/LO registers. It exports `busy`/`start` so the D-stage stall logic can hold later HI/LO instructions.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for mult/multu; at least 1.
- `DIV_CYCLES`, 10: busy cycles for div/divu; at least 1.

Ports:
- `clk`  in  1  sole clock; every register updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `valid`  in  1  E-stage instruction is real; 0 for a bubble.
- `instr`  in  32  E-stage instruction word.
- `rs_val`  in  WIDTH  forwarded GPR[rs].
- `rt_val`  in  WIDTH  forwarded GPR[rt].
- `start`  out  1  combinational: an accepted multi-cycle op is in E this cycle.
- `busy`  out  1  registered: an operation is in flight.
- `is_md`  out  1  combinational: `valid` and `instr` is any HI/LO-family instruction.
- `md_out`  out  WIDTH  combinational: HI for mfhi, LO for mflo, 0 otherwise.
- `hi`, `lo`  out  WIDTH each  current HI/LO register values.

## Operation
- Decode, opcode 000000 with funct:
  - 011000 mult, 011001 multu, 011010 div, 011011 divu
  - 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo
- Accept rule:
  - A start-class op (mult/multu/div/divu, plus madd family when configured) is accepted when `valid & !busy`.
  - `start` = accept.
- On accept:
  - Latch the result computed from `rs_val`/`rt_val` into internal `hi_nxt`/`lo_nxt`.
  - Load counter `cnt` with MULT_CYCLES or DIV_CYCLES.
- Each cycle with `cnt != 0`, `cnt` decrements. On the edge where `cnt` goes 1->0, HI<=`hi_nxt` and LO<=`lo_nxt`.
- `busy` = (`cnt != 0`), taken from the register.
- mult: signed 2·WIDTH product, {HI,LO}. multu: same, unsigned.
- div:
  - LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - INT_MIN / -1 gives LO=INT_MIN, HI=0.
- divu: unsigned quotient/remainder.
- Divisor 0: HI/LO keep their previous values, but `cnt` still runs the full DIV_CYCLES and `busy` behaves normally.
- mthi/mtlo with `valid & !busy`: HI (resp. LO) <= `rs_val` on the next edge.
- mfhi/mflo: `md_out` reflects the current register value, which includes a same-edge write from the previous cycle.
- The external stall unit guarantees no HI/LO-family instruction reaches E while `busy | start`. If one does anyway:
  - start-class ops and mthi/mtlo are ignored; there is no state change.
  - mfhi/mflo return the stale HI/LO.
- Reset (`reset_n`=0 at an edge): `cnt`=0, HI=0, LO=0, `hi_nxt`=`lo_nxt`=0, `busy`=0. An in-flight result is discarded.

## Timing
- Op in E during cycle k and accepted: `busy`=1 during cycles k+1 .. k+N, where N is the configured cycle count.
- HI/LO become the new values at the end of cycle k+N. They are visible, with `busy`=0, from cycle k+N+1.
- A back-to-back start is accepted in cycle k+N+1 at the earliest.
- mthi/mtlo in cycle k: the new value is visible from cycle k+1.
- Outputs after reset: `busy`=0, `hi`=`lo`=0. `start`, `is_md` and `md_out` are 0 whenever `valid`=0.

## Configuration
- `MD_MADD_EN` defined: decodes opcode 011100 with funct 000000 madd, 000001 maddu, 000100 msub, 000101 msubu.
  - The result is {HI,LO} ± product, using the HI/LO values at accept time.
  - Latency is MULT_CYCLES.
- `MD_MADD_EN` undefined: these encodings are not decoded. `is_md`=0 and `start`=0 for them, and HI/LO are unaffected.

## Test plan
- Reset, then mult with rs=0xFFFFFFFE (-2), rt=3, WIDTH=32, MULT_CYCLES=5 -> `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- divu 7/2, then div -7/2 (DIV_CYCLES=10) -> first HI=1, LO=3; second HI=0xFFFFFFFF, LO=0xFFFFFFFD; each after exactly 10 busy cycles.
- div by 0 after mthi 0x12, mtlo 0x34 -> `busy` still 10 cycles; HI=0x12, LO=0x34 unchanged.
- mult, then mflo in E while `busy`=1 -> mult result intact. mflo after busy falls -> `md_out` = LO.
- `reset_n`=0 at busy cycle 3 of div -> next cycle `busy`=0, HI=LO=0. A fresh divu is accepted immediately.
- With `MD_MADD_EN`: HI=0, LO=10, then madd rs=2, rt=3 -> LO=16, HI=0. Without it: `is_md`=0 and HI/LO unchanged.
